// File: rtl/rf_sched_pkg.sv
// Shared types for the register-file scheduler: FSM states, result codes, operation kinds.
package rf_sched_pkg;

  localparam int unsigned RESULT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [RESULT_W-1:0] {
    RES_OK      = 3'd0,
    RES_FULL    = 3'd1,
    RES_MATCH   = 3'd2,
    RES_NOMATCH = 3'd3,
    RES_DUP     = 3'd4
  } result_e;

  typedef enum logic [1:0] {
    OP_DEL = 2'd0,
    OP_VER = 2'd1,
    OP_ENR = 2'd2
  } op_e;

endpackage

// File: rtl/rf_slot_scanner.sv
// Slot scanner: walks the RF read address from 0 and flags code hits and free slots.
module rf_slot_scanner #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned CODE_W    = 16,
  localparam int unsigned AW       = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              adv_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic [CODE_W:0]   rd_data_i,
  output logic [AW-1:0]     addr_o,
  output logic              last_c,
  output logic              hit_c,
  output logic              free_c
);

  logic [AW-1:0] addr_q;

  // Address counter: cleared on grant, stepped once per scan cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
    end else if (clr_i) begin
      addr_q <= '0;
    end else if (adv_i) begin
      addr_q <= addr_q + AW'(1);
    end
  end

  assign addr_o = addr_q;
  assign last_c = (addr_q == AW'(NUM_SLOTS - 1));
  assign hit_c  = rd_data_i[CODE_W] && (rd_data_i[CODE_W-1:0] == code_i);
  assign free_c = !rd_data_i[CODE_W];

endmodule

// File: rtl/rf_scheduler.sv
// Register-file scheduler: arbitrates enroll/verify/delete and sequences RF scans/writes.
// Optional macro DUP_CHECK_EN: enroll scans every slot and reports DUP on an existing code.
module rf_scheduler
  import rf_sched_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned CODE_W    = 16,
  localparam int unsigned AW       = $clog2(NUM_SLOTS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enr_req,
  input  logic                ver_req,
  input  logic                del_req,
  input  logic [CODE_W-1:0]   enr_code,
  input  logic [CODE_W-1:0]   ver_code,
  input  logic [AW-1:0]       del_slot,
  output logic                enr_ack,
  output logic                ver_ack,
  output logic                del_ack,
  output logic [AW-1:0]       rd_addr,
  input  logic [CODE_W:0]     rd_data,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [CODE_W:0]     wr_data,
  output logic                busy,
  output logic                done,
  output logic [RESULT_W-1:0] result,
  output logic [AW-1:0]       result_slot
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [AW-1:0]     slot_q, slot_d;
  result_e           res_q, res_d;
  logic [AW-1:0]     res_slot_q, res_slot_d;
  logic              busy_q, done_q, wr_en_q;
  logic [AW-1:0]     wr_addr_q;
  logic [CODE_W:0]   wr_data_q;

  logic              scan_clr, scan_adv, scan_last, scan_hit, scan_free;
  logic [AW-1:0]     scan_addr;

`ifdef DUP_CHECK_EN
  logic              dup_seen_q, dup_seen_d, free_seen_q, free_seen_d;
  logic [AW-1:0]     dup_slot_q, dup_slot_d, free_slot_q, free_slot_d;
`endif

  rf_slot_scanner #(
    .NUM_SLOTS (NUM_SLOTS),
    .CODE_W    (CODE_W)
  ) u_scanner (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (scan_clr),
    .adv_i     (scan_adv),
    .code_i    (code_q),
    .rd_data_i (rd_data),
    .addr_o    (scan_addr),
    .last_c    (scan_last),
    .hit_c     (scan_hit),
    .free_c    (scan_free)
  );

  // Next-state, grant and result decode; acks are combinational so they pulse in the IDLE cycle.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    code_d     = code_q;
    slot_d     = slot_q;
    res_d      = res_q;
    res_slot_d = res_slot_q;
    enr_ack    = 1'b0;
    ver_ack    = 1'b0;
    del_ack    = 1'b0;
    scan_clr   = 1'b0;
    scan_adv   = 1'b0;
`ifdef DUP_CHECK_EN
    dup_seen_d  = dup_seen_q;
    dup_slot_d  = dup_slot_q;
    free_seen_d = free_seen_q;
    free_slot_d = free_slot_q;
`endif
    case (state_q)
      IDLE: begin
        if (reset_n) begin
          if (del_req) begin
            del_ack = 1'b1;
            op_d    = OP_DEL;
            slot_d  = del_slot;
            state_d = WRITE;
          end else if (ver_req) begin
            ver_ack  = 1'b1;
            op_d     = OP_VER;
            code_d   = ver_code;
            scan_clr = 1'b1;
            state_d  = SCAN;
          end else if (enr_req) begin
            enr_ack  = 1'b1;
            op_d     = OP_ENR;
            code_d   = enr_code;
            scan_clr = 1'b1;
            state_d  = SCAN;
`ifdef DUP_CHECK_EN
            dup_seen_d  = 1'b0;
            free_seen_d = 1'b0;
`endif
          end
        end
      end
      SCAN: begin
        scan_adv = 1'b1;
        if (op_q == OP_VER) begin
          if (scan_hit) begin
            state_d    = DONE;
            res_d      = RES_MATCH;
            res_slot_d = scan_addr;
          end else if (scan_last) begin
            state_d    = DONE;
            res_d      = RES_NOMATCH;
            res_slot_d = '0;
          end
        end else begin
`ifdef DUP_CHECK_EN
          if (scan_hit && !dup_seen_q) begin
            dup_seen_d = 1'b1;
            dup_slot_d = scan_addr;
          end
          if (scan_free && !free_seen_q) begin
            free_seen_d = 1'b1;
            free_slot_d = scan_addr;
          end
          if (scan_last) begin
            if (dup_seen_q || scan_hit) begin
              state_d    = DONE;
              res_d      = RES_DUP;
              res_slot_d = dup_seen_q ? dup_slot_q : scan_addr;
            end else if (free_seen_q || scan_free) begin
              state_d = WRITE;
              slot_d  = free_seen_q ? free_slot_q : scan_addr;
            end else begin
              state_d    = DONE;
              res_d      = RES_FULL;
              res_slot_d = '0;
            end
          end
`else
          if (scan_free) begin
            state_d = WRITE;
            slot_d  = scan_addr;
          end else if (scan_last) begin
            state_d    = DONE;
            res_d      = RES_FULL;
            res_slot_d = '0;
          end
`endif
        end
      end
      WRITE: begin
        state_d    = DONE;
        res_d      = RES_OK;
        res_slot_d = slot_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured operands and registered outputs, decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= OP_DEL;
      code_q     <= '0;
      slot_q     <= '0;
      res_q      <= RES_OK;
      res_slot_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      op_q       <= op_d;
      code_q     <= code_d;
      slot_q     <= slot_d;
      res_q      <= res_d;
      res_slot_q <= res_slot_d;
      busy_q     <= (state_d == SCAN) || (state_d == WRITE);
      done_q     <= (state_d == DONE);
      wr_en_q    <= (state_d == WRITE);
      wr_addr_q  <= (state_d == WRITE) ? slot_d : '0;
      wr_data_q  <= ((state_d == WRITE) && (op_d == OP_ENR)) ? {1'b1, code_d} : '0;
    end
  end

`ifdef DUP_CHECK_EN
  // Duplicate / first-free trackers for the full-scan enroll.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dup_seen_q  <= 1'b0;
      dup_slot_q  <= '0;
      free_seen_q <= 1'b0;
      free_slot_q <= '0;
    end else begin
      dup_seen_q  <= dup_seen_d;
      dup_slot_q  <= dup_slot_d;
      free_seen_q <= free_seen_d;
      free_slot_q <= free_slot_d;
    end
  end
`endif

  assign rd_addr     = scan_addr;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = res_q;
  assign result_slot = res_slot_q;

endmodule
